// File: rtl/lcd_sw_pkg.sv
// Shared constants for the stopwatch display link: register map, FSM states, reset values.
package lcd_sw_pkg;

  localparam int unsigned FRAME_W    = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned RD_ADDR_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_NOOP      = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_DECODE    = 4'h9;
  localparam logic [ADDR_W-1:0] ADDR_INTENSITY = 4'hA;
  localparam logic [ADDR_W-1:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [ADDR_W-1:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [ADDR_W-1:0] ADDR_TEST      = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

  localparam logic [DATA_W-1:0] RST_DIGIT      = 8'h00;
  localparam logic [DATA_W-1:0] RST_DECODE     = 8'h00;
  localparam logic [3:0]        RST_INTENSITY  = 4'h0;
  localparam logic [2:0]        RST_SCANLIM    = 3'h0;
  localparam logic              RST_SHUTDOWN_N = 1'b0;
  localparam logic              RST_TEST       = 1'b0;

endpackage

// File: rtl/lcd_sw_spi_rx_if.sv
// Serial display link: SPI mode-0 lines plus the daisy-chain return.
interface lcd_sw_spi_rx_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic dout;

  modport master (output sck, output cs_n, output mosi, input dout);
  modport slave  (input sck, input cs_n, input mosi, output dout);
endinterface

// File: rtl/lcd_sw_sync_edge.sv
// N-stage synchronizer with rise/fall pulses from the last stage versus one extra copy.
module lcd_sw_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Reset to 0 so a line already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= STAGES'({sync, d});
      prev <= sync[STAGES-1];
    end
  end

  assign q      = sync[STAGES-1];
  assign rise_c =  sync[STAGES-1] & ~prev;
  assign fall_c = ~sync[STAGES-1] &  prev;

endmodule

// File: rtl/lcd_sw_spi_rx.sv
// Oversampled SPI responder for 16-bit MAX7219-style register writes; holds digit/control regs.
module lcd_sw_spi_rx
  import lcd_sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_sw_spi_rx_if.slave       spi,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [DATA_W-1:0]    decode_mode,
  output logic [3:0]           intensity,
  output logic [2:0]           scan_limit,
  output logic                 shutdown_n,
  output logic                 display_test,
  output logic                 frame_valid,
  output logic                 frame_err
);

  logic sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c, mosi_s;
  logic [1:0] sync_q_unused;
  logic [1:0] mosi_edge_unused;

  lcd_sw_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(spi.sck),
    .q(sync_q_unused[0]), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  lcd_sw_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi.cs_n),
    .q(sync_q_unused[1]), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  lcd_sw_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi.mosi),
    .q(mosi_s), .rise_c(mosi_edge_unused[0]), .fall_c(mosi_edge_unused[1])
  );

  state_t                            state, state_nxt;
  logic [FRAME_W-1:0]                sr, sr_nxt;
  logic [CNT_W-1:0]                  cnt, cnt_nxt;
  logic                              dout_q, dout_nxt;
  logic                              valid_nxt, err_nxt;
  logic [NUM_DIGITS-1:0][DATA_W-1:0] digit, digit_nxt;
  logic [DATA_W-1:0]                 decode_nxt;
  logic [3:0]                        intensity_nxt;
  logic [2:0]                        scan_nxt;
  logic                              shutdown_nxt, test_nxt;
  logic [ADDR_W-1:0]                 addr_c;
  logic [DATA_W-1:0]                 data_c;

  assign addr_c = sr[11:8];
  assign data_c = sr[7:0];

  // Next-state, shift datapath and register-file writes.
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    cnt_nxt       = cnt;
    dout_nxt      = dout_q;
    valid_nxt     = 1'b0;
    err_nxt       = 1'b0;
    digit_nxt     = digit;
    decode_nxt    = decode_mode;
    intensity_nxt = intensity;
    scan_nxt      = scan_limit;
    shutdown_nxt  = shutdown_n;
    test_nxt      = display_test;
    case (state)
      ST_IDLE: begin
        if (cs_fall_c) begin
          cnt_nxt   = '0;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A frame end in the same cycle as an sck edge swallows that edge.
        if (cs_rise_c) begin
          state_nxt = ST_COMMIT;
        end else begin
          if (sck_rise_c) begin
            sr_nxt = {sr[FRAME_W-2:0], mosi_s};
            if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
          end
          if (sck_fall_c) dout_nxt = sr[FRAME_W-1];
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_IDLE;
        if (cnt == CNT_W'(FRAME_W)) begin
          valid_nxt = 1'b1;
          case (addr_c)
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
              digit_nxt[RD_ADDR_W'(addr_c - ADDR_DIGIT0)] = data_c;
            ADDR_DECODE:    decode_nxt    = data_c;
            ADDR_INTENSITY: intensity_nxt = data_c[3:0];
            ADDR_SCANLIM:   scan_nxt      = data_c[2:0];
            ADDR_SHUTDOWN:  shutdown_nxt  = data_c[0];
            ADDR_TEST:      test_nxt      = data_c[0];
            ADDR_NOOP:      ;
            default:        ;
          endcase
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sr           <= '0;
      cnt          <= '0;
      dout_q       <= 1'b0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      digit        <= {NUM_DIGITS{RST_DIGIT}};
      decode_mode  <= RST_DECODE;
      intensity    <= RST_INTENSITY;
      scan_limit   <= RST_SCANLIM;
      shutdown_n   <= RST_SHUTDOWN_N;
      display_test <= RST_TEST;
    end else begin
      state        <= state_nxt;
      sr           <= sr_nxt;
      cnt          <= cnt_nxt;
      dout_q       <= dout_nxt;
      frame_valid  <= valid_nxt;
      frame_err    <= err_nxt;
      digit        <= digit_nxt;
      decode_mode  <= decode_nxt;
      intensity    <= intensity_nxt;
      scan_limit   <= scan_nxt;
      shutdown_n   <= shutdown_nxt;
      display_test <= test_nxt;
    end
  end

  assign spi.dout = dout_q;
  assign rd_data  = digit[rd_addr];

endmodule

// File: tb/tb_lcd_sw_spi_rx.sv
// Directed + randomized bench for lcd_sw_spi_rx against a frame-level register model.
module tb_lcd_sw_spi_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rd_addr;
  logic [7:0] rd_data, decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown_n, display_test, frame_valid, frame_err;

  lcd_sw_spi_rx_if spi();

  lcd_sw_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi), .rd_addr(rd_addr), .rd_data(rd_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nv    = 0;
  int ne    = 0;

  logic [7:0] m_digit [8];
  logic [7:0] m_decode;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic       m_shut, m_test;
  logic       dout_seen [64];

  always @(negedge clk) begin
    if (frame_valid) nv++;
    if (frame_err)   ne++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0; m_shut = 1'b0; m_test = 1'b0;
  endfunction

  function automatic void model_apply(input logic [15:0] f);
    int a;
    a = int'(f[11:8]);
    if (a >= 1 && a <= 8) m_digit[a-1] = f[7:0];
    else if (a == 9)  m_decode = f[7:0];
    else if (a == 10) m_int    = f[3:0];
    else if (a == 11) m_scan   = f[2:0];
    else if (a == 12) m_shut   = f[0];
    else if (a == 15) m_test   = f[0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each bit: 4 clk low with mosi set, 4 clk high; dout is sampled just before each rise.
  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int j = 0; j < n; j++) begin
      spi.mosi = v[n-1-j];
      tick(4);
      dout_seen[j] = spi.dout;
      spi.sck = 1'b1;
      tick(4);
      spi.sck = 1'b0;
    end
  endtask

  task automatic send(input logic [63:0] v, input int n);
    tick(1);
    spi.cs_n = 1'b0;
    tick(4);
    shift_bits(v, n);
    tick(4);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_decode"},   32'(decode_mode),  32'(m_decode));
    check({tag, "_int"},      32'(intensity),    32'(m_int));
    check({tag, "_scan"},     32'(scan_limit),   32'(m_scan));
    check({tag, "_shut"},     32'(shutdown_n),   32'(m_shut));
    check({tag, "_test"},     32'(display_test), 32'(m_test));
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("%s_digit%0d", tag, i), 32'(rd_data), 32'(m_digit[i]));
    end
  endtask

  // Raise cs_n and expect the pulse exactly on the 4th edge sampling it high.
  task automatic end_frame(input string tag, input logic ev, input logic ee, input int dig);
    int v0, e0;
    v0 = nv;
    e0 = ne;
    @(posedge clk);
    #1;
    spi.cs_n = 1'b1;
    if (dig >= 0) rd_addr = 3'(dig);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, "_early"}, 32'({frame_valid, frame_err}), 32'(2'b00));
    end
    @(negedge clk);
    check({tag, "_pulse"}, 32'({frame_valid, frame_err}), 32'({ev, ee}));
    if (dig >= 0) check({tag, "_rd_same_cycle"}, 32'(rd_data), 32'(m_digit[dig]));
    tick(8);
    check({tag, "_nvalid"}, 32'(nv - v0), 32'(ev));
    check({tag, "_nerr"},   32'(ne - e0), 32'(ee));
  endtask

  task automatic do_frame(input string tag, input logic [63:0] v, input int n, input int dig);
    if (n == 16) model_apply(v[15:0]);
    send(v, n);
    end_frame(tag, n == 16, n != 16, dig);
    check_regs(tag);
  endtask

  initial begin
    logic [63:0] v;
    int          n;
    rst_n = 1'b0; spi.cs_n = 1'b1; spi.sck = 1'b0; spi.mosi = 1'b0; rd_addr = 3'd0;
    model_reset();
    tick(3);
    check_regs("reset");
    check("reset_dout", 32'(spi.dout), 32'(0));
    check("reset_pulses", 32'({frame_valid, frame_err}), 32'(0));
    rst_n = 1'b1;
    tick(6);
    check("post_reset_pulses", 32'(nv + ne), 32'(0));

    do_frame("shutdown", 64'h0C01, 16, 0);
    do_frame("digit0",   64'h0135, 16, 0);
    do_frame("digit7",   64'h08A7, 16, 7);
    do_frame("int_ff",   64'h0AFF, 16, -1);
    do_frame("scan_ff",  64'h0BFF, 16, -1);
    do_frame("decode",   64'hF95A, 16, -1);
    do_frame("test_on",  64'h0F03, 16, -1);
    do_frame("noop",     64'h00EE, 16, -1);
    do_frame("addr_d",   64'h0D12, 16, -1);
    do_frame("addr_e",   64'h0E34, 16, -1);
    do_frame("short15",  64'h00AB, 15, 0);
    do_frame("long17",   64'h102AB, 17, 0);
    do_frame("burst40",  {24'h0, 8'hC1, 32'h35DE_A001}, 40, 0);

    // Two frames in one window: the second half must echo the first 16 bits on dout.
    v = 64'h0155_0266;
    do_frame("double32", v, 32, 0);
    for (int j = 16; j < 32; j++)
      check($sformatf("dout_replay%0d", j - 16), 32'(dout_seen[j]), 32'(v[47-j]));

    for (int r = 0; r < 24; r++) begin
      v = {32'h0, $urandom};
      case ($urandom_range(0, 5))
        0:       n = 15;
        1:       n = 17;
        default: n = 16;
      endcase
      do_frame($sformatf("rand%0d", r), v, n, $urandom_range(0, 7));
    end

    do_frame("pre_rst", 64'h0C01, 16, -1);
    tick(1);
    spi.cs_n = 1'b0;
    tick(4);
    shift_bits(64'h0C, 8);
    rst_n = 1'b0;
    model_reset();
    tick(2);
    check_regs("midrst");
    check("midrst_dout", 32'(spi.dout), 32'(0));
    check("midrst_pulses", 32'({frame_valid, frame_err}), 32'(0));
    rst_n = 1'b1;
    tick(2);
    shift_bits(64'h01, 8);
    tick(4);
    end_frame("rst_tail", 1'b0, 1'b0, -1);
    check_regs("rst_tail");
    do_frame("after_rst", 64'h0C01, 16, -1);
    do_frame("after_rst_dig", 64'h0542, 16, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_sw_spi_rx.md
# lcd_sw_spi_rx

SPI responder that accepts 16-bit display-controller frames (MAX7219-style register writes) and holds the resulting digit and control registers. It is the receiving end of the stopwatch's serial display link: used on-chip as a loopback target for the stopwatch's display transmitter and as a chained second display stage. All SPI inputs are oversampled in the single `clk` domain; there is no SPI-clocked logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `sck`, `cs_n`, `mosi`.

Ports:
- `clk`, input, 1: system clock. One clock domain only.
- `rst_n`, input, 1: asynchronous active-low reset.
- `sck`, input, 1: SPI clock, mode 0, sampled on its rising edge.
- `cs_n`, input, 1: active-low frame select.
- `mosi`, input, 1: serial data, MSB first.
- `dout`, output, 1: daisy-chain out. The shift-register MSB, updated on `sck` falling edges.
- `rd_addr`, input, 3: digit read select, 0..7, for digits 1..8.
- `rd_data`, output, 8: the selected digit register. Combinational.
- `decode_mode`, output, 8: register 0x9.
- `intensity`, output, 4: register 0xA, bits [3:0].
- `scan_limit`, output, 3: register 0xB, bits [2:0].
- `shutdown_n`, output, 1: register 0xC, bit 0.
- `display_test`, output, 1: register 0xF, bit 0.
- `frame_valid`, output, 1: one-cycle pulse when a well-formed frame is committed.
- `frame_err`, output, 1: one-cycle pulse when a frame is discarded.

## Operation
- Frame layout: 16 bits. [15:12] ignored, [11:8] address, [7:0] data.
- States:
  - IDLE: waits for the synced `cs_n` falling edge, then clears the bit counter and goes to SHIFT. A `cs_n` already low when reset releases is not a frame start.
  - SHIFT: on each synced `sck` rising edge, shift `mosi` into the 16-bit shift register and increment the 5-bit bit counter, which saturates at 31. On each synced `sck` falling edge, `dout` takes shift-register bit 15. On the synced `cs_n` rising edge, go to COMMIT.
  - COMMIT (1 cycle): if the bit count is exactly 16, decode and write the register, pulse `frame_valid`, then return to IDLE. Any other count discards the frame and pulses `frame_err`.
- Address decode:
  - 0x0: no-op. Still counts as valid.
  - 0x1–0x8: digit[addr-1] takes the data byte.
  - 0x9, 0xA, 0xB, 0xC, 0xF: write the matching control register.
  - 0xD, 0xE: ignored, but the frame is still valid.
- Width rules: `intensity` and `scan_limit` keep only their low bits. The upper data bits are dropped without error.
- Simultaneous events:
  - A `cs_n` rising edge and an `sck` edge detected in the same cycle: `cs_n` wins and the `sck` edge is ignored.
  - `sck` edges are ignored in IDLE.
- Reset mid-frame: the partial frame is lost, all registers return to reset values, and the FSM goes to IDLE with no pulse.
- Reset values:
  - All eight digits = 0x00.
  - `decode_mode` = 0x00, `intensity` = 0, `scan_limit` = 0.
  - `shutdown_n` = 0 (shutdown), `display_test` = 0.
  - `dout` = 0, `frame_valid` = 0, `frame_err` = 0.
  - Shift register = 0, bit counter = 0, state = IDLE.

## Timing
- Input synchronizer depth is `SYNC_STAGES`. The edge detector compares the last sync stage with one extra registered copy.
- `sck` high and low phases must each be at least 3 `clk` periods. `mosi` must be stable from 1 `clk` before to 1 `clk` after the `sck` rising edge at the pin.
- Commit latency, with `SYNC_STAGES`=2: registers update and `frame_valid`/`frame_err` assert 4 `clk` edges after the first edge that samples `cs_n` high. Both pulses last exactly 1 cycle and are never asserted together.
- `cs_n` high time must be at least 4 `clk` periods before the next falling edge. A shorter gap may lose the next frame start.
- `rd_data` follows `rd_addr` with zero latency, and reflects a commit in the same cycle as the `frame_valid` pulse.
- `dout` lags the `sck` falling edge at the pin by `SYNC_STAGES`+1 `clk` cycles.

## Structure
- Shared package `lcd_sw_pkg`:
  - Register address constants: ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIM, ADDR_SHUTDOWN, ADDR_TEST.
  - FSM state enum.
  - Reset-value constants.
- Sub-module `lcd_sw_sync_edge`: N-stage synchronizer plus rise/fall pulse outputs. Instantiated for `sck` and `cs_n`. `mosi` uses the same synchronizer with the edge outputs unused.

## Test plan
- Reset, then a frame 0x0C01 with 16 bits: `shutdown_n`=1, one `frame_valid` pulse, digits unchanged.
- Frames 0x0135 and 0x08A7: `rd_addr`=0 gives 0x35 and `rd_addr`=7 gives 0xA7. `frame_valid` pulses twice.
- Frame 0x0AFF: `intensity`=0xF. Frame 0x0BFF: `scan_limit`=7. Neither raises an error.
- Frames of 15 bits and of 17 bits, address 0x1: `frame_err` pulses each time and digit 0 is unchanged. A 40-bit burst saturates the counter and gives `frame_err`.
- Frame 0x0155 then 0x0266 in one `cs_n` window (32 bits): `frame_err`, and `dout` replays the first 16 bits in order during the second half.
- `rst_n` low after 8 bits of 0x0C01: all outputs return to reset values. A later `cs_n` rise gives no pulse, and the next full frame commits normally.
